// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// ID-stage hazard and forwarding controller for the MIPS pipeline.
// - Selects forwarding sources (EX/MEM/WB/RF) for both ID operands.
// - Holds the front end for LOAD_LATENCY cycles on a load-use hazard.
// - Handles external freeze (ext_stall) and squash (flush) requests.
// Optional feature: define HFU_STALL_CNT_EN to add a saturating
// stall_count output that counts cycles spent in load-use stall.

module pipeline_hazard_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  EX_Register_File_Enable,
  input  logic                  MEM_Register_File_Enable,
  input  logic                  WB_Register_File_Enable,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic [REG_ADDR_W-1:0] MEM_RD,
  input  logic [REG_ADDR_W-1:0] WB_RD,
  input  logic [REG_ADDR_W-1:0] operandA,
  input  logic [REG_ADDR_W-1:0] operandB,
  input  logic                  use_A,
  input  logic                  use_B,
  input  logic                  EX_load_instr,
  input  logic                  ext_stall,
  input  logic                  flush,
  output logic [1:0]            forwardMX1,
  output logic [1:0]            forwardMX2,
  output logic                  nPC_LE,
  output logic                  PC_LE,
  output logic                  IF_ID_LE,
  output logic                  ID_bubble,
  output logic                  IF_ID_flush
`ifdef HFU_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // Remaining stall cycles loaded when a hazard is first seen; the hit
  // cycle itself is the first of the LOAD_LATENCY stall cycles.
  localparam logic [2:0] REM_INIT    = 3'(LOAD_LATENCY - 1);
  localparam bit         MULTI_CYCLE = (LOAD_LATENCY > 1);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  state_t     state;
  logic [2:0] rem;
  logic       hit;
  logic       stall_req;
  logic       stall_taken;

  // Priority forwarding select for one operand; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] op,
    input logic                  use_op,
    input logic                  ex_en,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic                  mem_en,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  wb_en,
    input logic [REG_ADDR_W-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_op && (op != ZERO_REG)) begin
      if (ex_en && (ex_rd != ZERO_REG) && (ex_rd == op)) begin
        sel = 2'b01;
      end else if (mem_en && (mem_rd != ZERO_REG) && (mem_rd == op)) begin
        sel = 2'b10;
      end else if (wb_en && (wb_rd != ZERO_REG) && (wb_rd == op)) begin
        sel = 2'b11;
      end
    end
    return sel;
  endfunction

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    hit = EX_load_instr && EX_Register_File_Enable && (EX_RD != ZERO_REG) &&
          ((use_A && (operandA == EX_RD)) || (use_B && (operandB == EX_RD)));
    stall_req   = (state == STALL) || hit;
    stall_taken = !reset && !flush && !ext_stall && stall_req;
  end

  // Output decode: reset > flush > ext_stall > load-use stall > normal.
  always_comb begin
    forwardMX1  = 2'b00;
    forwardMX2  = 2'b00;
    nPC_LE      = 1'b1;
    PC_LE       = 1'b1;
    IF_ID_LE    = 1'b1;
    ID_bubble   = 1'b0;
    IF_ID_flush = 1'b0;
    if (!reset) begin
      forwardMX1 = fwd_sel(operandA, use_A,
                           EX_Register_File_Enable, EX_RD,
                           MEM_Register_File_Enable, MEM_RD,
                           WB_Register_File_Enable, WB_RD);
      forwardMX2 = fwd_sel(operandB, use_B,
                           EX_Register_File_Enable, EX_RD,
                           MEM_Register_File_Enable, MEM_RD,
                           WB_Register_File_Enable, WB_RD);
      if (flush) begin
        IF_ID_flush = 1'b1;
        ID_bubble   = 1'b1;
      end else if (ext_stall) begin
        nPC_LE   = 1'b0;
        PC_LE    = 1'b0;
        IF_ID_LE = 1'b0;
      end else if (stall_req) begin
        nPC_LE    = 1'b0;
        PC_LE     = 1'b0;
        IF_ID_LE  = 1'b0;
        ID_bubble = 1'b1;
      end
    end
  end

  // Stall FSM: extends multi-cycle load-use stalls; frozen by ext_stall, cleared by flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem   <= 3'd0;
    end else if (flush) begin
      state <= IDLE;
      rem   <= 3'd0;
    end else if (!ext_stall) begin
      case (state)
        IDLE: begin
          if (hit && MULTI_CYCLE) begin
            state <= STALL;
            rem   <= REM_INIT;
          end
        end
        STALL: begin
          if (rem <= 3'd1) begin
            state <= IDLE;
            rem   <= 3'd0;
          end else begin
            rem <= rem - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          rem   <= 3'd0;
        end
      endcase
    end
  end

`ifdef HFU_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] cnt_q;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  // Saturating count of cycles in which the load-use stall actually held the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (stall_taken && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign stall_count = cnt_q;
`else
  logic unused_stall_cnt;
  assign unused_stall_cnt = stall_taken & (STALL_CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: two instances (LOAD_LATENCY
// 1 and 2) see identical stimulus; expected outputs are queued per step and a
// negedge monitor pops and compares them.

module tb_pipeline_hazard_controller;

  typedef struct packed {
    logic       rst;
    logic       exen, memen, wben;
    logic [4:0] exrd, memrd, wbrd, opa, opb;
    logic       ua, ub, ld, ext, fl;
  } stim_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic [2:0] le;
    logic       bub, flu;
  } exp_t;

  typedef struct {
    int         step;
    exp_t       e1;
    exp_t       e2;
    logic [1:0] cnt;
    logic       chk;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       ex_en = 1'b0, mem_en = 1'b0, wb_en = 1'b0;
  logic [4:0] ex_rd = '0, mem_rd = '0, wb_rd = '0, op_a = '0, op_b = '0;
  logic       use_a = 1'b0, use_b = 1'b0, ld = 1'b0, ext = 1'b0, fl = 1'b0;

  logic [1:0] f1_a, f2_a, f1_b, f2_b;
  logic       npc_a, pc_a, ifid_a, bub_a, flu_a;
  logic       npc_b, pc_b, ifid_b, bub_b, flu_b;
`ifdef HFU_STALL_CNT_EN
  logic [1:0] cnt_a, cnt_b;
`endif

  int errors = 0;
  int checks = 0;
  int step_no = 0;
  item_t sb[$];

  pipeline_hazard_controller #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .STALL_CNT_W(2)) dut1 (
    .clk(clk), .reset(reset),
    .EX_Register_File_Enable(ex_en), .MEM_Register_File_Enable(mem_en),
    .WB_Register_File_Enable(wb_en),
    .EX_RD(ex_rd), .MEM_RD(mem_rd), .WB_RD(wb_rd),
    .operandA(op_a), .operandB(op_b), .use_A(use_a), .use_B(use_b),
    .EX_load_instr(ld), .ext_stall(ext), .flush(fl),
    .forwardMX1(f1_a), .forwardMX2(f2_a),
    .nPC_LE(npc_a), .PC_LE(pc_a), .IF_ID_LE(ifid_a),
    .ID_bubble(bub_a), .IF_ID_flush(flu_a)
`ifdef HFU_STALL_CNT_EN
    , .stall_count(cnt_a)
`endif
  );

  pipeline_hazard_controller #(.REG_ADDR_W(5), .LOAD_LATENCY(2), .STALL_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .EX_Register_File_Enable(ex_en), .MEM_Register_File_Enable(mem_en),
    .WB_Register_File_Enable(wb_en),
    .EX_RD(ex_rd), .MEM_RD(mem_rd), .WB_RD(wb_rd),
    .operandA(op_a), .operandB(op_b), .use_A(use_a), .use_B(use_b),
    .EX_load_instr(ld), .ext_stall(ext), .flush(fl),
    .forwardMX1(f1_b), .forwardMX2(f2_b),
    .nPC_LE(npc_b), .PC_LE(pc_b), .IF_ID_LE(ifid_b),
    .ID_bubble(bub_b), .IF_ID_flush(flu_b)
`ifdef HFU_STALL_CNT_EN
    , .stall_count(cnt_b)
`endif
  );

  function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                              input logic le, input logic bub, input logic flu);
    exp_t e;
    e.fa  = fa;
    e.fb  = fb;
    e.le  = {3{le}};
    e.bub = bub;
    e.flu = flu;
    return e;
  endfunction

  function automatic stim_t base();
    stim_t s;
    s = '0;
    s.exen  = 1'b1;
    s.memen = 1'b1;
    s.wben  = 1'b1;
    return s;
  endfunction

  // Drive one cycle of stimulus just after the edge and queue its expectation.
  task automatic applyStimulus(input stim_t s, input exp_t e1, input exp_t e2,
                               input logic [1:0] cnt, input logic chk);
    item_t it;
    @(posedge clk);
    #1;
    reset  = s.rst;
    ex_en  = s.exen;  mem_en = s.memen; wb_en = s.wben;
    ex_rd  = s.exrd;  mem_rd = s.memrd; wb_rd = s.wbrd;
    op_a   = s.opa;   op_b   = s.opb;
    use_a  = s.ua;    use_b  = s.ub;
    ld     = s.ld;    ext    = s.ext;   fl    = s.fl;
    it.step = step_no;
    it.e1   = e1;
    it.e2   = e2;
    it.cnt  = cnt;
    it.chk  = chk;
    sb.push_back(it);
    step_no++;
  endtask

  task automatic checkOutput(input int step, input string what,
                             input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL step %0d %s: got %0h expected %0h", step, what, got, exp);
    end
  endtask

  // Monitor: compare every queued expectation against the DUTs mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      checkOutput(it.step, "ll1_fwd1", {6'd0, f1_a}, {6'd0, it.e1.fa});
      checkOutput(it.step, "ll1_fwd2", {6'd0, f2_a}, {6'd0, it.e1.fb});
      checkOutput(it.step, "ll1_le", {5'd0, npc_a, pc_a, ifid_a}, {5'd0, it.e1.le});
      checkOutput(it.step, "ll1_bubble", {7'd0, bub_a}, {7'd0, it.e1.bub});
      checkOutput(it.step, "ll1_flush", {7'd0, flu_a}, {7'd0, it.e1.flu});
      checkOutput(it.step, "ll2_fwd1", {6'd0, f1_b}, {6'd0, it.e2.fa});
      checkOutput(it.step, "ll2_fwd2", {6'd0, f2_b}, {6'd0, it.e2.fb});
      checkOutput(it.step, "ll2_le", {5'd0, npc_b, pc_b, ifid_b}, {5'd0, it.e2.le});
      checkOutput(it.step, "ll2_bubble", {7'd0, bub_b}, {7'd0, it.e2.bub});
      checkOutput(it.step, "ll2_flush", {7'd0, flu_b}, {7'd0, it.e2.flu});
`ifdef HFU_STALL_CNT_EN
      if (it.chk) begin
        checkOutput(it.step, "ll1_stall_count", {6'd0, cnt_a}, {6'd0, it.cnt});
      end
`endif
    end
  end

  initial begin
    stim_t s;
    exp_t  nrm;
    s   = base();
    nrm = mk(2'd0, 2'd0, 1'b1, 1'b0, 1'b0);

    // Reset: forwarding would match but must read 00
    s.rst = 1'b1; s.exrd = 5'd3; s.opa = 5'd3; s.ua = 1'b1;
    applyStimulus(s, nrm, nrm, 2'd0, 1'b0);
    applyStimulus(s, nrm, nrm, 2'd0, 1'b1);

    // Forwarding priority on operand A
    s.rst = 1'b0; s.memrd = 5'd3; s.wbrd = 5'd3;
    applyStimulus(s, mk(2'd1, 2'd0, 1, 0, 0), mk(2'd1, 2'd0, 1, 0, 0), 2'd0, 1'b1);
    s.exrd = 5'd4;
    applyStimulus(s, mk(2'd2, 2'd0, 1, 0, 0), mk(2'd2, 2'd0, 1, 0, 0), 2'd0, 1'b1);
    s.memrd = 5'd5;
    applyStimulus(s, mk(2'd3, 2'd0, 1, 0, 0), mk(2'd3, 2'd0, 1, 0, 0), 2'd0, 1'b1);
    s.opa = 5'd0;
    applyStimulus(s, nrm, nrm, 2'd0, 1'b1);

    // Operand B: use_B gating, then EX disabled falls through to MEM
    s.opb = 5'd4; s.ub = 1'b0;
    applyStimulus(s, nrm, nrm, 2'd0, 1'b1);
    s.ub = 1'b1;
    applyStimulus(s, mk(2'd0, 2'd1, 1, 0, 0), mk(2'd0, 2'd1, 1, 0, 0), 2'd0, 1'b1);
    s.exen = 1'b0; s.memrd = 5'd4; s.wbrd = 5'd4;
    applyStimulus(s, mk(2'd0, 2'd2, 1, 0, 0), mk(2'd0, 2'd2, 1, 0, 0), 2'd0, 1'b1);

    // Load-use hazard on B, load then moves to MEM and WB
    s.exen = 1'b1; s.ld = 1'b1; s.exrd = 5'd7; s.opb = 5'd7; s.ua = 1'b0;
    s.memrd = 5'd0; s.wbrd = 5'd0;
    applyStimulus(s, mk(2'd0, 2'd1, 0, 1, 0), mk(2'd0, 2'd1, 0, 1, 0), 2'd0, 1'b1);
    s.ld = 1'b0; s.exrd = 5'd0; s.memrd = 5'd7;
    applyStimulus(s, mk(2'd0, 2'd2, 1, 0, 0), mk(2'd0, 2'd2, 0, 1, 0), 2'd1, 1'b1);
    s.memrd = 5'd0; s.wbrd = 5'd7;
    applyStimulus(s, mk(2'd0, 2'd3, 1, 0, 0), mk(2'd0, 2'd3, 1, 0, 0), 2'd1, 1'b1);

    // Hazard, then 3 frozen cycles, then the remaining stall cycle for LL=2
    s.ld = 1'b1; s.exrd = 5'd7; s.wbrd = 5'd0;
    applyStimulus(s, mk(2'd0, 2'd1, 0, 1, 0), mk(2'd0, 2'd1, 0, 1, 0), 2'd1, 1'b1);
    s.ld = 1'b0; s.exrd = 5'd0; s.memrd = 5'd7; s.ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(s, mk(2'd0, 2'd2, 0, 0, 0), mk(2'd0, 2'd2, 0, 0, 0), 2'd2, 1'b1);
    end
    s.ext = 1'b0;
    applyStimulus(s, mk(2'd0, 2'd2, 1, 0, 0), mk(2'd0, 2'd2, 0, 1, 0), 2'd2, 1'b1);
    s.memrd = 5'd0; s.wbrd = 5'd7;
    applyStimulus(s, mk(2'd0, 2'd3, 1, 0, 0), mk(2'd0, 2'd3, 1, 0, 0), 2'd2, 1'b1);

    // Flush coincident with a hit: no stall taken now or next cycle
    s.ld = 1'b1; s.exrd = 5'd7; s.wbrd = 5'd0; s.fl = 1'b1;
    applyStimulus(s, mk(2'd0, 2'd1, 1, 1, 1), mk(2'd0, 2'd1, 1, 1, 1), 2'd2, 1'b1);
    s.fl = 1'b0; s.ld = 1'b0; s.exrd = 5'd0; s.memrd = 5'd7;
    applyStimulus(s, mk(2'd0, 2'd2, 1, 0, 0), mk(2'd0, 2'd2, 1, 0, 0), 2'd2, 1'b1);

    // Repeated hits: counter saturates at 3
    s.ld = 1'b1; s.exrd = 5'd7; s.memrd = 5'd0;
    applyStimulus(s, mk(2'd0, 2'd1, 0, 1, 0), mk(2'd0, 2'd1, 0, 1, 0), 2'd2, 1'b1);
    applyStimulus(s, mk(2'd0, 2'd1, 0, 1, 0), mk(2'd0, 2'd1, 0, 1, 0), 2'd3, 1'b1);
    applyStimulus(s, mk(2'd0, 2'd1, 0, 1, 0), mk(2'd0, 2'd1, 0, 1, 0), 2'd3, 1'b1);

    // Reset while LL=2 instance is in STALL, then released with no hazard
    s.rst = 1'b1; s.ld = 1'b0; s.exrd = 5'd0; s.memrd = 5'd7;
    applyStimulus(s, nrm, nrm, 2'd3, 1'b1);
    s.rst = 1'b0;
    applyStimulus(s, mk(2'd0, 2'd2, 1, 0, 0), mk(2'd0, 2'd2, 1, 0, 0), 2'd0, 1'b1);

    // use_A=0 with matching operandA: no stall and no count
    s.ld = 1'b1; s.exrd = 5'd7; s.memrd = 5'd0; s.opa = 5'd7; s.ua = 1'b0;
    s.opb = 5'd0; s.ub = 1'b0;
    applyStimulus(s, nrm, nrm, 2'd0, 1'b1);
    applyStimulus(s, nrm, nrm, 2'd0, 1'b1);

    // Hazard through operand A
    s.ua = 1'b1;
    applyStimulus(s, mk(2'd1, 2'd0, 0, 1, 0), mk(2'd1, 2'd0, 0, 1, 0), 2'd0, 1'b1);
    s.ld = 1'b0; s.exrd = 5'd0; s.memrd = 5'd7;
    applyStimulus(s, mk(2'd2, 2'd0, 1, 0, 0), mk(2'd2, 2'd0, 0, 1, 0), 2'd1, 1'b1);
    s.memrd = 5'd0;
    applyStimulus(s, nrm, nrm, 2'd1, 1'b1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Parametrised hazard/forwarding controller for the MIPS pipeline, driven from the ID stage. It selects forwarding sources for both ID operands from EX, MEM and WB. A stall FSM holds the front end for a configurable number of load-use cycles, and the block also handles external freeze and flush requests. It drives the PC/nPC/IF-ID load enables and the ID/EX bubble control.

## Interface
Parameters:
- REG_ADDR_W, 5, register-specifier width.
- LOAD_LATENCY, 1, stall cycles per load-use hazard; legal range 1..7. 1 means load data is forwardable from MEM; 2 means WB only.
- STALL_CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- EX_Register_File_Enable, MEM_Register_File_Enable, WB_Register_File_Enable  in  1 each  stage writes RF.
- EX_RD, MEM_RD, WB_RD  in  REG_ADDR_W each  stage destination.
- operandA, operandB  in  REG_ADDR_W each  ID source specifiers.
- use_A, use_B  in  1 each  ID instruction actually reads the operand.
- EX_load_instr  in  1  EX holds a load.
- ext_stall  in  1  freeze the whole pipeline (e.g. memory not ready).
- flush  in  1  squash IF/ID (branch redirect/exception).
- forwardMX1, forwardMX2  out  2 each  00 RF, 01 EX, 10 MEM, 11 WB.
- nPC_LE, PC_LE, IF_ID_LE  out  1 each  load enables.
- ID_bubble  out  1  zero ID/EX control fields.
- IF_ID_flush  out  1  clear IF/ID.
- stall_count  out  STALL_CNT_W  only with HFU_STALL_CNT_EN.

## Operation
- Forwarding is combinational, evaluated per operand X in {A,B}, in priority order:
  - EX (01) if EX_Register_File_Enable && EX_RD==operandX;
  - else MEM (10);
  - else WB (11);
  - else 00.
  - A stage never matches when its RD==0.
  - operandX==0 or use_X==0 forces 00.
- Hazard detect: hit = EX_load_instr && EX_Register_File_Enable && EX_RD!=0 && ((use_A && operandA==EX_RD) || (use_B && operandB==EX_RD)).
- FSM states: IDLE and STALL, with a 3-bit remaining counter rem.
  - IDLE:
    - hit → stall asserted this cycle.
    - If LOAD_LATENCY>1, go to STALL with rem=LOAD_LATENCY-1. Otherwise stay in IDLE.
  - STALL:
    - Stall asserted regardless of hit; rem decrements each cycle.
    - In the cycle rem==1, go to IDLE.
- Output priority: reset > flush > ext_stall > stall > normal.
  - flush: IF_ID_flush=1, ID_bubble=1, all LE=1; FSM goes to IDLE, rem=0.
  - ext_stall: all LE=0, ID_bubble=0, IF_ID_flush=0; FSM state and rem hold.
  - stall: all LE=0, ID_bubble=1, IF_ID_flush=0.
  - normal: all LE=1, ID_bubble=0, IF_ID_flush=0.
- Forward selects are driven in all cases except reset.

## Timing
- Forward selects, LEs, ID_bubble and IF_ID_flush are combinational from inputs and registered state. There is no added latency: a hazard visible in cycle N stalls in cycle N.
- Load-use stall length is exactly LOAD_LATENCY non-frozen cycles. ext_stall cycles extend it without consuming rem.
- When the stall ends, the load sits at MEM (LOAD_LATENCY=1) or WB (LOAD_LATENCY=2), and forwarding selects 10 or 11 respectively.
- A new hit in the cycle the FSM returns to IDLE starts a fresh stall in the following cycle. Back-to-back loads are therefore handled.
- Simultaneous flush and hit: flush wins, and no stall is taken.
- Reset (while high, and registers after the edge):
  - state=IDLE, rem=0, stall_count=0;
  - outputs forward 00, LE=1, ID_bubble=0, IF_ID_flush=0.
- Reset mid-STALL aborts the stall.

## Configuration
- HFU_STALL_CNT_EN defined:
  - stall_count increments by 1 on every clock in which the load-use stall output is asserted and reset is low.
  - Flush cycles and ext_stall-only cycles do not count.
  - Saturates at all-ones.
- Undefined: the stall_count port and its register are absent.

## Test plan
- Forwarding priority (reset low, all RF enables=1): EX_RD=MEM_RD=WB_RD=3, operandA=3, use_A=1 → forwardMX1=01. Set EX_RD=4 → 10. Set MEM_RD=5 → 11. Set operandA=0 → 00.
- Load-use stall, LOAD_LATENCY=1: EX_load_instr=1, EX_RD=7, operandB=7, use_B=1 for one cycle; next cycle the load is in MEM with MEM_RD=7, EX_load_instr=0.
  - Cycle 1: PC_LE/nPC_LE/IF_ID_LE=0, ID_bubble=1.
  - Cycle 2: all LE=1, forwardMX2=10.
- LOAD_LATENCY=2, same stimulus: stall for 2 cycles, the second independent of inputs. In cycle 3 the load is in WB with WB_RD=7 → forwardMX2=11, all LE=1.
- ext_stall=1 for 3 cycles starting in STALL cycle 1 (LOAD_LATENCY=2):
  - Those 3 cycles: LE=0, ID_bubble=0.
  - Then exactly 1 more stall cycle with ID_bubble=1.
- flush=1 coincident with a hit → IF_ID_flush=1, ID_bubble=1, LE=1, FSM IDLE. With LOAD_LATENCY=2, the next cycle is not stalled. Reset asserted mid-STALL → next cycle IDLE, LE=1.
- HFU_STALL_CNT_EN, STALL_CNT_W=2: 5 hazard stall cycles → stall_count=3 (saturated). Reset → 0. use_A=0 with matching operandA → no stall, no count.
